uart_rx: RTL and testbench

Serial receiver for the 8N1 UART link: it samples an asynchronous `rx` line, detects and validates the start bit, and shifts in 8 data bits LSB-first at mid-bit. It checks the stop bit and presents each byte with a one-cycle `valid` strobe, or flags a framing error. The block sits at the far end of the line driven by `uart_tx`, and together they form the two halves of the UART.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync2.sv | 26 ++
 rtl/uart_rx.sv | 129 ++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period and the FSM state
// encoding used by both the receiver and the transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL sets the value both flops take in reset (the line's idle level).
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops are written with non-blocking assignments so that q takes the
    // previous value of meta and the chain really is two stages deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-bit glitch filter, mid-bit sampling of LSB-first
// data, stop-bit check with one-cycle valid / frame_err strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      frame_err,
    output logic                      busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_e               state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [2:0]                bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      rx_s;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; without it a
        // path that skips an assignment would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // Re-check the line at mid start bit; a high level was a glitch.
                if (cnt_q == HALF_CNT) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BREAK: begin
                // A line held low must go idle before a new start is accepted.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for back-to-back, glitch, break, reset abort and loopback.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation of the strobes, away from the active edge.
    logic [7:0] vq[$];
    int         vcyc[$];
    int         ferr_n = 0;
    int         ferr_cyc = -1;
    int         both_n = 0;
    int         busy_hi_n = 0;
    int         busy_falls = 0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                vq.push_back(data);
                vcyc.push_back(cyc);
            end
            if (frame_err) begin
                ferr_n++;
                ferr_cyc = cyc;
            end
            if (valid && frame_err) both_n++;
            if (busy) busy_hi_n++;
            if (prev_busy && !busy) busy_falls++;
            prev_busy = busy;
        end else begin
            prev_busy = 1'b0;
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one 8N1 frame; caller is at a negedge and returns at a negedge.
    // With gap == 0 the line is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap,
                              output int start);
        logic [9:0] fr;
        fr    = {stop, b, 1'b0};
        start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        if (gap > 0) begin
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    // rx falls at a negedge; two sync flops plus one IDLE cycle plus
    // CPB/2 + 9*CPB sample cycles put the strobe 155 posedges later.
    localparam int STROBE_LAT = 3 + CPB / 2 + 9 * CPB;

    initial begin
        int s, s2, v0, f0, h0, b0;
        logic [7:0] lb[256];

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[3] = '{8'h3C, 1'b0, 8'hFF, 0, 1};
        vecs[4] = '{8'h5A, 1'b1, 8'h5A, 1, 0};
        vecs[5] = '{8'h81, 1'b1, 8'h81, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Table of single frames
        for (int i = 0; i < 6; i++) begin
            v0 = vq.size();
            f0 = ferr_n;
            send_frame(vecs[i].b, vecs[i].stop, 20, s);
            check($sformatf("vec%0d_nvalid", i), 32'(vq.size() - v0), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_nferr", i), 32'(ferr_n - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
            if (vecs[i].exp_valid == 1 && vq.size() > v0)
                check($sformatf("vec%0d_vcyc", i), 32'(vcyc[v0]), 32'(s + STROBE_LAT));
            else if (vecs[i].exp_ferr == 1)
                check($sformatf("vec%0d_fcyc", i), 32'(ferr_cyc), 32'(s + STROBE_LAT));
        end

        // Back-to-back 00 then FF with a single stop bit
        v0 = vq.size();
        b0 = busy_falls;
        send_frame(8'h00, 1'b1, 0, s);
        send_frame(8'hFF, 1'b1, 20, s2);
        check("b2b_nvalid", 32'(vq.size() - v0), 32'd2);
        if (vq.size() >= v0 + 2) begin
            check("b2b_data0", 32'(vq[v0]), 32'h00);
            check("b2b_data1", 32'(vq[v0+1]), 32'hFF);
            check("b2b_vcyc1", 32'(vcyc[v0+1]), 32'(s2 + STROBE_LAT));
        end
        check("b2b_busy_falls", 32'(busy_falls - b0), 32'd2);

        // 5-cycle glitch
        v0 = vq.size();
        f0 = ferr_n;
        h0 = busy_hi_n;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_nvalid", 32'(vq.size() - v0), 32'd0);
        check("glitch_nferr", 32'(ferr_n - f0), 32'd0);
        check("glitch_busy_len", 32'(busy_hi_n - h0), 32'd8);

        // Bad stop bit followed by a held-low line
        v0 = vq.size();
        f0 = ferr_n;
        send_frame(8'h3C, 1'b0, 0, s);
        repeat (40) @(negedge clk);
        check("brk_nferr", 32'(ferr_n - f0), 32'd1);
        check("brk_fcyc", 32'(ferr_cyc), 32'(s + STROBE_LAT));
        check("brk_data_kept", 32'(data), 32'hFF);
        check("brk_busy_held", 32'(busy), 32'h1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("brk_busy_clear", 32'(busy), 32'h0);
        check("brk_nvalid", 32'(vq.size() - v0), 32'd0);
        check("brk_nferr_after", 32'(ferr_n - f0), 32'd1);

        // Reset during bit 4 of 5A, then a clean C3
        begin
            logic [9:0] fr;
            fr = {1'b1, 8'h5A, 1'b0};
            for (int i = 0; i < 5; i++) begin
                rx = fr[i];
                repeat (CPB) @(negedge clk);
            end
            rx = fr[5];
            repeat (CPB / 2) @(negedge clk);
        end
        v0 = vq.size();
        f0 = ferr_n;
        rst_n = 1'b0;
        #1;
        check("abort_data", 32'(data), 32'h00);
        check("abort_valid", 32'(valid), 32'h0);
        check("abort_ferr", 32'(frame_err), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_nostrobe", 32'(vq.size() - v0 + ferr_n - f0), 32'd0);
        send_frame(8'hC3, 1'b1, 20, s);
        check("abort_nvalid", 32'(vq.size() - v0), 32'd1);
        check("abort_newdata", 32'(data), 32'hC3);
        check("abort_nferr", 32'(ferr_n - f0), 32'd0);

        // Loopback of random bytes, back-to-back frames
        v0 = vq.size();
        f0 = ferr_n;
        for (int i = 0; i < 256; i++) begin
            lb[i] = 8'($urandom_range(255));
            send_frame(lb[i], 1'b1, 0, s);
        end
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("loop_nvalid", 32'(vq.size() - v0), 32'd256);
        check("loop_nferr", 32'(ferr_n - f0), 32'd0);
        for (int i = 0; i < 256; i++) begin
            if (v0 + i < vq.size())
                check($sformatf("loop_byte%0d", i), 32'(vq[v0+i]), 32'(lb[i]));
        end

        check("never_both", 32'(both_n), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
